// File: rtl/lock_pkg.sv
// Shared types and width helpers for the serial code lock.
package lock_pkg;

  typedef enum logic [1:0] {ENTRY, OPEN, PROG, LOCKOUT} lock_state_t;

  localparam int FIRST_DIGIT = 0;

  // Width of a counter that must hold values 0..n-1, never narrower than one bit.
  function automatic int count_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module lock_timer #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         enable,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (enable && (count != '0))
      count <= count - W'(1);
  end

  assign done = (count == '0);

endmodule

// File: rtl/seq_code_lock.sv
// Serial combination lock with retry limit, timed lockout, timed open window
// and code reprogramming while open.
//
//   state   | meaning
//   --------+--------------------------------------------------------
//   ENTRY   | collecting digits and comparing them against the code
//   OPEN    | unlocked, timed window; prog_req moves to PROG
//   PROG    | unlocked, collecting a new code into the shadow array
//   LOCKOUT | too many wrong entries; all input ignored until timeout
module seq_code_lock
  import lock_pkg::*;
#(
  parameter int DIGIT_W        = 4,
  parameter int CODE_LEN       = 4,
  parameter logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE = 16'h1234,
  parameter int MAX_TRIES      = 3,
  parameter int LOCKOUT_CYCLES = 16,
  parameter int OPEN_CYCLES    = 8
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             digit_valid,
  input  logic [DIGIT_W-1:0]               digit,
  input  logic                             clear,
  input  logic                             prog_req,
  output logic                             unlocked,
  output logic                             lockout,
  output logic                             fail_pulse,
  output logic                             prog_done,
  output logic [$clog2(CODE_LEN+1)-1:0]    position,
  output logic [$clog2(MAX_TRIES+1)-1:0]   tries_left
);

  localparam int POS_W = $clog2(CODE_LEN + 1);
  localparam int TRY_W = $clog2(MAX_TRIES + 1);
  localparam int IDX_W = $clog2(CODE_LEN);
  localparam int TMR_W = count_w(max_int(OPEN_CYCLES, LOCKOUT_CYCLES));
  localparam logic [POS_W-1:0] LAST_POS = POS_W'(CODE_LEN - 1);

  lock_state_t state, state_n;
  logic [DIGIT_W-1:0] code   [CODE_LEN];
  logic [DIGIT_W-1:0] code_n [CODE_LEN];
  logic [DIGIT_W-1:0] shadow   [CODE_LEN];
  logic [DIGIT_W-1:0] shadow_n [CODE_LEN];
  logic               mismatch, mismatch_n, miss;
  logic [POS_W-1:0]   position_n;
  logic [TRY_W-1:0]   tries_n;
  logic               unlocked_n, lockout_n, fail_n, done_n;
  logic               tmr_load, tmr_done, tmr_en;
  logic [TMR_W-1:0]   tmr_val;
  logic [IDX_W-1:0]   idx;

  assign idx    = position[IDX_W-1:0];
  assign tmr_en = (state == OPEN) || (state == LOCKOUT);

  lock_timer #(.W(TMR_W)) u_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .enable   (tmr_en),
    .done     (tmr_done)
  );

  always_comb begin
    state_n    = state;
    code_n     = code;
    shadow_n   = shadow;
    mismatch_n = mismatch;
    position_n = position;
    tries_n    = tries_left;
    unlocked_n = unlocked;
    lockout_n  = lockout;
    fail_n     = 1'b0;
    done_n     = 1'b0;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    miss       = mismatch | (digit != code[idx]);
    case (state)
      ENTRY: begin
        if (clear) begin
          position_n = POS_W'(FIRST_DIGIT);
          mismatch_n = 1'b0;
        end else if (digit_valid) begin
          if (position == LAST_POS) begin
            position_n = POS_W'(FIRST_DIGIT);
            mismatch_n = 1'b0;
            if (!miss) begin
              state_n    = OPEN;
              unlocked_n = 1'b1;
              tries_n    = TRY_W'(MAX_TRIES);
              tmr_load   = 1'b1;
              tmr_val    = TMR_W'(OPEN_CYCLES - 1);
            end else begin
              fail_n = 1'b1;
              if (tries_left > TRY_W'(1)) begin
                tries_n = tries_left - TRY_W'(1);
              end else begin
                tries_n   = '0;
                state_n   = LOCKOUT;
                lockout_n = 1'b1;
                tmr_load  = 1'b1;
                tmr_val   = TMR_W'(LOCKOUT_CYCLES - 1);
              end
            end
          end else begin
            position_n = position + POS_W'(1);
            mismatch_n = miss;
          end
        end
      end
      OPEN: begin
        // prog_req wins over the window expiring in the same cycle
        if (prog_req) begin
          state_n    = PROG;
          position_n = POS_W'(FIRST_DIGIT);
        end else if (tmr_done) begin
          state_n    = ENTRY;
          unlocked_n = 1'b0;
          position_n = POS_W'(FIRST_DIGIT);
        end
      end
      PROG: begin
        if (clear) begin
          state_n    = ENTRY;
          unlocked_n = 1'b0;
          position_n = POS_W'(FIRST_DIGIT);
        end else if (digit_valid) begin
          shadow_n[idx] = digit;
          if (position == LAST_POS) begin
            code_n     = shadow_n;
            done_n     = 1'b1;
            state_n    = ENTRY;
            unlocked_n = 1'b0;
            position_n = POS_W'(FIRST_DIGIT);
          end else begin
            position_n = position + POS_W'(1);
          end
        end
      end
      LOCKOUT: begin
        if (tmr_done) begin
          state_n    = ENTRY;
          lockout_n  = 1'b0;
          tries_n    = TRY_W'(MAX_TRIES);
          position_n = POS_W'(FIRST_DIGIT);
        end
      end
      default: state_n = ENTRY;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ENTRY;
      mismatch   <= 1'b0;
      position   <= '0;
      tries_left <= TRY_W'(MAX_TRIES);
      unlocked   <= 1'b0;
      lockout    <= 1'b0;
      fail_pulse <= 1'b0;
      prog_done  <= 1'b0;
      for (int i = 0; i < CODE_LEN; i++) begin
        code[i]   <= DEFAULT_CODE[(CODE_LEN-1-i)*DIGIT_W +: DIGIT_W];
        shadow[i] <= '0;
      end
    end else begin
      state      <= state_n;
      mismatch   <= mismatch_n;
      position   <= position_n;
      tries_left <= tries_n;
      unlocked   <= unlocked_n;
      lockout    <= lockout_n;
      fail_pulse <= fail_n;
      prog_done  <= done_n;
      code       <= code_n;
      shadow     <= shadow_n;
    end
  end

endmodule

// File: tb/tb_seq_code_lock.sv
// Self-checking bench for seq_code_lock: vector table, directed corner cases
// and random traffic against a queue-based reference model.
module tb_seq_code_lock;

  localparam int DW    = 4;
  localparam int LEN   = 4;
  localparam int MAXT  = 3;
  localparam int LOCKC = 16;
  localparam int OPENC = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic          digit_valid, clear, prog_req;
  logic [DW-1:0] digit;
  logic          unlocked, lockout, fail_pulse, prog_done;
  logic [2:0]    position;
  logic [1:0]    tries_left;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  seq_code_lock #(
    .DIGIT_W(DW), .CODE_LEN(LEN), .DEFAULT_CODE(16'h1234),
    .MAX_TRIES(MAXT), .LOCKOUT_CYCLES(LOCKC), .OPEN_CYCLES(OPENC)
  ) dut (
    .clock(clock), .reset(reset), .digit_valid(digit_valid), .digit(digit),
    .clear(clear), .prog_req(prog_req), .unlocked(unlocked), .lockout(lockout),
    .fail_pulse(fail_pulse), .prog_done(prog_done), .position(position),
    .tries_left(tries_left)
  );

  // Reference model: digit queues plus remaining-cycle counts for the windows.
  int m_code[LEN];
  int m_entry[$];
  int m_prog[$];
  int m_open, m_lock, m_tries;
  bit m_progging, m_fail, m_done;

  function automatic void model_reset();
    m_code = '{1, 2, 3, 4};
    m_entry.delete();
    m_prog.delete();
    m_open = 0; m_lock = 0; m_tries = MAXT;
    m_progging = 0; m_fail = 0; m_done = 0;
  endfunction

  function automatic void model_step(input bit dv, input int d, input bit clr, input bit pr);
    bit ok;
    m_fail = 0;
    m_done = 0;
    if (m_lock > 0) begin
      m_lock--;
      if (m_lock == 0) m_tries = MAXT;
    end else if (m_progging) begin
      if (clr) begin
        m_progging = 0;
        m_prog.delete();
      end else if (dv) begin
        m_prog.push_back(d);
        if (m_prog.size() == LEN) begin
          for (int i = 0; i < LEN; i++) m_code[i] = m_prog[i];
          m_prog.delete();
          m_progging = 0;
          m_done = 1;
        end
      end
    end else if (m_open > 0) begin
      if (pr) begin
        m_open = 0;
        m_progging = 1;
      end else begin
        m_open--;
      end
    end else begin
      if (clr) begin
        m_entry.delete();
      end else if (dv) begin
        m_entry.push_back(d);
        if (m_entry.size() == LEN) begin
          ok = 1;
          for (int i = 0; i < LEN; i++) if (m_entry[i] != m_code[i]) ok = 0;
          m_entry.delete();
          if (ok) begin
            m_open = OPENC;
            m_tries = MAXT;
          end else begin
            m_fail = 1;
            m_tries--;
            if (m_tries == 0) m_lock = LOCKC;
          end
        end
      end
    end
  endfunction

  task automatic check_outputs(input string name);
    int e_pos;
    bit e_u;
    e_pos = m_progging ? m_prog.size() : m_entry.size();
    e_u   = (m_open > 0) || m_progging;
    checks++;
    if (unlocked !== e_u || lockout !== (m_lock > 0) || fail_pulse !== m_fail ||
        prog_done !== m_done || position !== 3'(e_pos) || tries_left !== 2'(m_tries)) begin
      errors++;
      $display("FAIL %s @%0t got u=%0d l=%0d f=%0d d=%0d pos=%0d tries=%0d exp u=%0d l=%0d f=%0d d=%0d pos=%0d tries=%0d",
               name, $time, unlocked, lockout, fail_pulse, prog_done, position, tries_left,
               e_u, (m_lock > 0), m_fail, m_done, e_pos, m_tries);
    end
  endtask

  task automatic expect_val(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s @%0t got %0d exp %0d", name, $time, act, exp);
    end
  endtask

  task automatic cycle(input bit dv, input int d, input bit clr, input bit pr, input string name);
    digit_valid = dv;
    digit       = DW'(d);
    clear       = clr;
    prog_req    = pr;
    @(posedge clock);
    model_step(dv, d, clr, pr);
    #1;
    check_outputs(name);
  endtask

  task automatic enter(input int a, input int b, input int c, input int d, input string name);
    cycle(1, a, 0, 0, name);
    cycle(1, b, 0, 0, name);
    cycle(1, c, 0, 0, name);
    cycle(1, d, 0, 0, name);
  endtask

  task automatic idle(input int n, input string name);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, name);
  endtask

  // Asynchronous reset pulse between clock edges.
  task automatic pulse_reset(input string name);
    reset = 1'b1;
    #1;
    model_reset();
    check_outputs(name);
    expect_val({name, "_tries"}, int'(tries_left), MAXT);
    #1;
    reset = 1'b0;
  endtask

  typedef struct {
    bit    dv;
    int    d;
    bit    clr;
    bit    pr;
    bit    u;
    bit    f;
    int    pos;
    int    tries;
    string name;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input bit dv, input int d, input bit clr, input bit u,
                              input bit f, input int pos, input int tries, input string name);
    vec_t v;
    v.dv = dv; v.d = d; v.clr = clr; v.pr = 0;
    v.u = u; v.f = f; v.pos = pos; v.tries = tries; v.name = name;
    tbl.push_back(v);
  endfunction

  initial begin
    reset = 1'b1; digit_valid = 0; digit = '0; clear = 0; prog_req = 0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_outputs("reset_state");
    expect_val("reset_tries", int'(tries_left), 3);
    reset = 1'b0;

    // Wrong entry, correct entry, open window, clear handling.
    add(1, 1, 0, 0, 0, 1, 3, "bad_d0");
    add(1, 2, 0, 0, 0, 2, 3, "bad_d1");
    add(1, 3, 0, 0, 0, 3, 3, "bad_d2");
    add(1, 5, 0, 0, 1, 0, 2, "bad_last");
    add(0, 0, 0, 0, 0, 0, 2, "after_fail");
    add(1, 1, 0, 0, 0, 1, 2, "good_d0");
    add(1, 2, 0, 0, 0, 2, 2, "good_d1");
    add(1, 3, 0, 0, 0, 3, 2, "good_d2");
    add(1, 4, 0, 1, 0, 0, 3, "good_last");
    for (int i = 0; i < OPENC - 1; i++) add(0, 0, 0, 1, 0, 0, 3, "open_hold");
    add(0, 0, 0, 0, 0, 0, 3, "open_end");
    add(1, 1, 0, 0, 0, 1, 3, "clr_d0");
    add(1, 2, 0, 0, 0, 2, 3, "clr_d1");
    add(0, 0, 1, 0, 0, 0, 3, "clear");
    add(1, 1, 1, 0, 0, 0, 3, "clear_and_digit");
    add(1, 1, 0, 0, 0, 1, 3, "after_clear_d0");
    add(0, 0, 1, 0, 0, 0, 3, "clear2");

    foreach (tbl[i]) begin
      cycle(tbl[i].dv, tbl[i].d, tbl[i].clr, tbl[i].pr, tbl[i].name);
      checks++;
      if (unlocked !== tbl[i].u || fail_pulse !== tbl[i].f ||
          position !== 3'(tbl[i].pos) || tries_left !== 2'(tbl[i].tries) || lockout !== 1'b0) begin
        errors++;
        $display("FAIL tbl_%s got u=%0d f=%0d l=%0d pos=%0d tries=%0d exp u=%0d f=%0d l=0 pos=%0d tries=%0d",
                 tbl[i].name, unlocked, fail_pulse, lockout, position, tries_left,
                 tbl[i].u, tbl[i].f, tbl[i].pos, tbl[i].tries);
      end
    end

    // Three wrong entries, then the correct code inside the lockout window.
    enter(1, 1, 1, 1, "lk_try1");
    enter(2, 2, 2, 2, "lk_try2");
    enter(4, 3, 2, 1, "lk_try3");
    expect_val("lk_entered", int'(lockout), 1);
    expect_val("lk_tries0", int'(tries_left), 0);
    enter(1, 2, 3, 4, "lk_ignored");
    expect_val("lk_no_unlock", int'(unlocked), 0);
    idle(LOCKC - 5, "lk_wait");
    expect_val("lk_last_cycle", int'(lockout), 1);
    idle(1, "lk_exit");
    expect_val("lk_released", int'(lockout), 0);
    expect_val("lk_tries_restored", int'(tries_left), 3);

    // Reprogram to 9,8,7,6 and confirm old code fails, new code opens.
    enter(1, 2, 3, 4, "pg_unlock");
    cycle(0, 0, 0, 1, "pg_req");
    expect_val("pg_unlocked_in_prog", int'(unlocked), 1);
    enter(9, 8, 7, 6, "pg_digits");
    expect_val("pg_done_pulse", int'(prog_done), 1);
    expect_val("pg_relocked", int'(unlocked), 0);
    idle(1, "pg_idle");
    expect_val("pg_done_one_cycle", int'(prog_done), 0);
    enter(1, 2, 3, 4, "pg_old_code");
    expect_val("pg_old_fails", int'(fail_pulse), 1);
    enter(9, 8, 7, 6, "pg_new_code");
    expect_val("pg_new_opens", int'(unlocked), 1);
    idle(OPENC, "pg_close");

    // Reset mid-PROG: partial code discarded, default restored.
    enter(9, 8, 7, 6, "rp_unlock");
    cycle(0, 0, 0, 1, "rp_req");
    cycle(1, 5, 0, 0, "rp_d0");
    cycle(1, 5, 0, 0, "rp_d1");
    pulse_reset("rst_mid_prog");
    enter(1, 2, 3, 4, "rp_default");
    expect_val("rp_default_opens", int'(unlocked), 1);
    idle(OPENC, "rp_close");

    // Reset mid-LOCKOUT.
    enter(0, 0, 0, 0, "rl_try1");
    enter(0, 0, 0, 0, "rl_try2");
    enter(0, 0, 0, 0, "rl_try3");
    idle(5, "rl_wait");
    pulse_reset("rst_mid_lockout");
    enter(1, 2, 3, 4, "rl_default");
    expect_val("rl_default_opens", int'(unlocked), 1);
    idle(OPENC, "rl_close");

    // Random traffic biased toward the current code so every state is visited.
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 699) == 0) begin
        pulse_reset("rand_reset");
      end else begin
        bit dv, clr, pr;
        int d;
        dv  = ($urandom_range(0, 9) < 6);
        clr = ($urandom_range(0, 24) == 0);
        pr  = ($urandom_range(0, 4) == 0);
        if (!m_progging && $urandom_range(0, 4) != 0)
          d = m_code[m_entry.size()];
        else
          d = int'($urandom_range(0, 15));
        cycle(dv, d, clr, pr, "rand");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
